// File: rtl/remote_cmd_snd_if.sv
// Command, UART and result signals of the remote-side command sender.
// The sender is the slave; whoever issues commands and models the UART is the master.
interface remote_cmd_snd_if;
  logic        snd_cmd;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        rdy;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [7:0]  resp;
  logic        resp_vld;
  logic        tmo;

  modport master (
    output snd_cmd, cmd, data, tx_done, rx_rdy, rx_data,
    input  rdy, tx_data, trmt, clr_rx_rdy, resp, resp_vld, tmo
  );

  modport slave (
    input  snd_cmd, cmd, data, tx_done, rx_rdy, rx_data,
    output rdy, tx_data, trmt, clr_rx_rdy, resp, resp_vld, tmo
  );
endinterface

// File: rtl/remote_cmd_snd.sv
// Sends a 24-bit command as three UART bytes (cmd, data hi, data lo), then waits
// for a one-byte response from the quadcopter or reports a timeout.
module remote_cmd_snd #(
  parameter int TMO_WIDTH = 20
) (
  input logic              clk,
  input logic              rst_n,
  remote_cmd_snd_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    TX_CMD,
    TX_HI,
    TX_LO,
    WAIT_RSP
  } state_t;

  state_t               r_state;
  logic [23:0]          r_shadow;
  logic [TMO_WIDTH-1:0] r_cnt;
  logic [7:0]           r_tx_data;
  logic                 r_trmt;
  logic                 r_clr_rx_rdy;
  logic [7:0]           r_resp;
  logic                 r_resp_vld;
  logic                 r_tmo;

  // Strobes default low every cycle so each one lasts exactly one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shadow     <= '0;
      r_cnt        <= '0;
      r_tx_data    <= 8'h00;
      r_trmt       <= 1'b0;
      r_clr_rx_rdy <= 1'b0;
      r_resp       <= 8'h00;
      r_resp_vld   <= 1'b0;
      r_tmo        <= 1'b0;
    end else begin
      r_trmt       <= 1'b0;
      r_clr_rx_rdy <= 1'b0;
      r_resp_vld   <= 1'b0;
      r_tmo        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.rx_rdy) begin
            r_clr_rx_rdy <= 1'b1;
          end
          if (bus.snd_cmd) begin
            r_shadow  <= {bus.cmd, bus.data};
            r_tx_data <= bus.cmd;
            r_trmt    <= 1'b1;
            r_state   <= TX_CMD;
          end
        end
        TX_CMD: begin
          if (bus.tx_done) begin
            r_tx_data <= r_shadow[15:8];
            r_trmt    <= 1'b1;
            r_state   <= TX_HI;
          end
        end
        TX_HI: begin
          if (bus.tx_done) begin
            r_tx_data <= r_shadow[7:0];
            r_trmt    <= 1'b1;
            r_state   <= TX_LO;
          end
        end
        TX_LO: begin
          if (bus.tx_done) begin
            r_cnt   <= '0;
            r_state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          r_cnt <= r_cnt + 1'b1;
          // A response arriving on the last counter value still beats the timeout.
          if (bus.rx_rdy) begin
            r_resp       <= bus.rx_data;
            r_resp_vld   <= 1'b1;
            r_clr_rx_rdy <= 1'b1;
            r_state      <= IDLE;
          end else if (&r_cnt) begin
            r_tmo   <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rdy        = (r_state == IDLE);
  assign bus.tx_data    = r_tx_data;
  assign bus.trmt       = r_trmt;
  assign bus.clr_rx_rdy = r_clr_rx_rdy;
  assign bus.resp       = r_resp;
  assign bus.resp_vld   = r_resp_vld;
  assign bus.tmo        = r_tmo;

endmodule

// File: tb/tb_remote_cmd_snd.sv
// Directed bench for remote_cmd_snd with a 4-bit timeout counter and a UART model
// that answers every trmt with tx_done ten cycles later.
module tb_remote_cmd_snd;

  logic clk;
  logic rst_n;

  remote_cmd_snd_if bus ();

  remote_cmd_snd #(.TMO_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checkCount    = 0;
  int errorCount    = 0;
  int trmtCount     = 0;
  int respVldCount  = 0;
  int clrCount      = 0;
  int tmoCount      = 0;
  int txDoneCount   = 0;
  int txCountdown   = 0;
  logic [7:0] txLog[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART transmitter model: logs each strobed byte, returns tx_done ten cycles later.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (txCountdown > 0) begin
        txCountdown--;
        if (txCountdown == 0) begin
          bus.tx_done = 1'b1;
          txDoneCount++;
        end
      end
      if (bus.trmt) begin
        txLog.push_back(bus.tx_data);
        txCountdown = 10;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.trmt)       trmtCount++;
    if (bus.resp_vld)   respVldCount++;
    if (bus.clr_rx_rdy) clrCount++;
    if (bus.tmo)        tmoCount++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitTxDone(input int target);
    int n = 0;
    while (txDoneCount < target && n < 300) begin
      tick();
      n++;
    end
    if (txDoneCount < target) checkOutput("txDoneWait", txDoneCount, target);
  endtask

  // Issue one command from IDLE and confirm it is accepted on the next edge.
  task automatic applyStimulus(input logic [7:0] c, input logic [15:0] d);
    bus.snd_cmd = 1'b1;
    bus.cmd     = c;
    bus.data    = d;
    tick();
    bus.snd_cmd = 1'b0;
    bus.cmd     = 8'hFF;
    bus.data    = 16'hFFFF;
    checkOutput("acceptRdy", bus.rdy, 1'b0);
    checkOutput("acceptTrmt", bus.trmt, 1'b1);
    checkOutput("acceptTxData", bus.tx_data, c);
  endtask

  task automatic respond(input logic [7:0] b);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    tick();
    bus.rx_rdy  = 1'b0;
  endtask

  int logBase;
  int doneBase;
  int trmtBase;
  int vldBase;
  int clrBase;
  int tmoBase;

  initial begin
    rst_n       = 1'b0;
    bus.snd_cmd = 1'b0;
    bus.cmd     = 8'h00;
    bus.data    = 16'h0000;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) tick();
    checkOutput("rstRdy", bus.rdy, 1'b1);
    checkOutput("rstTrmt", bus.trmt, 1'b0);
    checkOutput("rstTxData", bus.tx_data, 8'h00);
    checkOutput("rstResp", bus.resp, 8'h00);
    checkOutput("rstRespVld", bus.resp_vld, 1'b0);
    checkOutput("rstTmo", bus.tmo, 1'b0);
    checkOutput("rstClr", bus.clr_rx_rdy, 1'b0);
    rst_n = 1'b1;
    tick();

    $display("[TB] basic send with ack");
    logBase = txLog.size(); doneBase = txDoneCount; trmtBase = trmtCount;
    vldBase = respVldCount; clrBase = clrCount;
    applyStimulus(8'h02, 16'h1234);
    waitTxDone(doneBase + 3);
    tick();
    repeat (5) tick();
    checkOutput("basicWaitRdy", bus.rdy, 1'b0);
    respond(8'hA5);
    checkOutput("basicResp", bus.resp, 8'hA5);
    checkOutput("basicRespVld", bus.resp_vld, 1'b1);
    checkOutput("basicClr", bus.clr_rx_rdy, 1'b1);
    checkOutput("basicRdy", bus.rdy, 1'b1);
    tick();
    checkOutput("basicVldWidth", bus.resp_vld, 1'b0);
    checkOutput("basicByte0", txLog[logBase], 8'h02);
    checkOutput("basicByte1", txLog[logBase+1], 8'h12);
    checkOutput("basicByte2", txLog[logBase+2], 8'h34);
    checkOutput("basicTrmtCount", trmtCount - trmtBase, 3);
    checkOutput("basicVldCount", respVldCount - vldBase, 1);
    checkOutput("basicClrCount", clrCount - clrBase, 1);

    $display("[TB] battery request");
    doneBase = txDoneCount;
    applyStimulus(8'h01, 16'h0000);
    waitTxDone(doneBase + 3);
    tick();
    tick();
    respond(8'hC3);
    checkOutput("battResp", bus.resp, 8'hC3);
    checkOutput("battRespVld", bus.resp_vld, 1'b1);
    tick();
    checkOutput("battVldWidth", bus.resp_vld, 1'b0);

    $display("[TB] timeout");
    doneBase = txDoneCount;
    applyStimulus(8'h03, 16'h00FF);
    waitTxDone(doneBase + 3);
    tick();
    repeat (15) tick();
    checkOutput("tmoEarly", bus.tmo, 1'b0);
    checkOutput("tmoEarlyRdy", bus.rdy, 1'b0);
    tick();
    checkOutput("tmoPulse", bus.tmo, 1'b1);
    checkOutput("tmoRdy", bus.rdy, 1'b1);
    checkOutput("tmoRespHeld", bus.resp, 8'hC3);
    tick();
    checkOutput("tmoWidth", bus.tmo, 1'b0);

    $display("[TB] busy and stray byte");
    logBase = txLog.size(); doneBase = txDoneCount; trmtBase = trmtCount;
    applyStimulus(8'h04, 16'h5678);
    waitTxDone(doneBase + 1);
    tick();
    checkOutput("busyRdy", bus.rdy, 1'b0);
    bus.snd_cmd = 1'b1;
    bus.cmd     = 8'h05;
    bus.data    = 16'h9999;
    tick();
    bus.snd_cmd = 1'b0;
    waitTxDone(doneBase + 3);
    tick();
    respond(8'h11);
    checkOutput("busyResp", bus.resp, 8'h11);
    checkOutput("busyTrmtCount", trmtCount - trmtBase, 3);
    checkOutput("busyByte0", txLog[logBase], 8'h04);
    checkOutput("busyByte1", txLog[logBase+1], 8'h56);
    checkOutput("busyByte2", txLog[logBase+2], 8'h78);
    tick();
    vldBase = respVldCount;
    respond(8'hEE);
    checkOutput("strayClr", bus.clr_rx_rdy, 1'b1);
    checkOutput("strayRespVld", bus.resp_vld, 1'b0);
    checkOutput("strayResp", bus.resp, 8'h11);
    tick();
    checkOutput("strayVldCount", respVldCount - vldBase, 0);

    $display("[TB] response on last counter value");
    doneBase = txDoneCount; tmoBase = tmoCount;
    applyStimulus(8'h06, 16'h0102);
    waitTxDone(doneBase + 3);
    tick();
    repeat (15) tick();
    respond(8'h5A);
    checkOutput("simResp", bus.resp, 8'h5A);
    checkOutput("simRespVld", bus.resp_vld, 1'b1);
    checkOutput("simTmo", bus.tmo, 1'b0);
    repeat (3) tick();
    checkOutput("simTmoCount", tmoCount - tmoBase, 0);

    $display("[TB] reset mid-operation");
    doneBase = txDoneCount;
    applyStimulus(8'h08, 16'h0000);
    waitTxDone(doneBase + 1);
    tick();
    checkOutput("preRstTrmt", bus.trmt, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstTrmt", bus.trmt, 1'b0);
    checkOutput("asyncRstRdy", bus.rdy, 1'b1);
    checkOutput("asyncRstTxData", bus.tx_data, 8'h00);
    checkOutput("asyncRstResp", bus.resp, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    trmtBase = trmtCount; vldBase = respVldCount; tmoBase = tmoCount;
    repeat (30) tick();
    checkOutput("postRstTrmt", trmtCount - trmtBase, 0);
    checkOutput("postRstVld", respVldCount - vldBase, 0);
    checkOutput("postRstTmo", tmoCount - tmoBase, 0);
    checkOutput("postRstRdy", bus.rdy, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
